// File: rtl/key_event_queue.sv
// key_event_queue
//   Turns one-cycle debounced key press pulses into a stream of 2-bit key
//   codes. Pulses first land in a pending register. A fixed-priority arbiter
//   (lowest index first) moves at most one pending key per cycle into a
//   show-ahead FIFO, and the consumer drains the FIFO over valid/ready.
//   A pulse that arrives while its own key is still pending, and is not being
//   moved into the FIFO that cycle, is merged into the pending bit and is
//   therefore lost. Such a loss sets the sticky ovf flag.
//
//   Optional feature macro: KEY_QUEUE_DROP_CNT_EN
//     When defined, adds drop_cnt, a saturating 8-bit count of lost pulses.
//     ovf_clr also clears this count.
//
// Ports
//   mclk        in   1         system clock, rising edge
//   rst         in   1         asynchronous active-high reset
//   key_en      in   4         one-cycle press pulses, bit i = key i
//   evt_code    out  2         code at FIFO head, 0 when evt_valid is low
//   evt_valid   out  1         FIFO non-empty
//   evt_ready   in   1         consumer accepts the head entry
//   fifo_level  out  ADDR_W+1  number of stored entries, 0..2**ADDR_W
//   ovf         out  1         sticky: at least one pulse was lost
//   ovf_clr     in   1         clears ovf; a loss in the same cycle wins
//   drop_cnt    out  8         (macro only) saturating lost-pulse count
module key_event_queue #(
  parameter int ADDR_W = 3
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic [3:0]        key_en,
  output logic [1:0]        evt_code,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ADDR_W:0]   fifo_level,
  output logic              ovf,
  input  logic              ovf_clr
`ifdef KEY_QUEUE_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [1:0]        mem [DEPTH];
  logic [3:0]        pend_reg;
  logic [3:0]        pend_next;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   level_reg;
  logic [ADDR_W:0]   level_next;
  logic              ovf_reg;
  logic              ovf_next;

  logic              pop;
  logic              full;
  logic              push_ok;
  logic              push;
  logic [3:0]        grant;
  logic [4:0]        blocked;   // blocked[i]: some lower-index key is pending
  logic [3:0]        drop_vec;
  logic [1:0]        grant_code;

  // The level never exceeds DEPTH, so its MSB alone marks a full FIFO.
  assign full      = level_reg[ADDR_W];
  assign evt_valid = |level_reg;
  assign pop       = evt_valid & evt_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok   = ~full | pop;

  assign blocked[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      assign blocked[gi+1] = blocked[gi] | pend_reg[gi];
      assign grant[gi]     = push_ok & pend_reg[gi] & ~blocked[gi];
      // A new pulse on a key that stays pending this cycle cannot be stored.
      assign drop_vec[gi]  = key_en[gi] & pend_reg[gi] & ~grant[gi];
    end
  endgenerate

  assign push       = |grant;
  assign grant_code = {grant[3] | grant[2], grant[3] | grant[1]};
  assign pend_next  = (pend_reg & ~grant) | key_en;
  assign ovf_next   = (|drop_vec) | (ovf_reg & ~ovf_clr);

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      pend_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      pend_reg  <= pend_next;
      level_reg <= level_next;
      ovf_reg   <= ovf_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage is deliberately not reset; entries are only read once written.
  always_ff @(posedge mclk) begin
    if (push)
      mem[wr_ptr_reg] <= grant_code;
  end

  // Show-ahead head: the entry at rd_ptr is visible without a read request.
  assign evt_code   = evt_valid ? mem[rd_ptr_reg] : 2'b00;
  assign fifo_level = level_reg;
  assign ovf        = ovf_reg;

`ifdef KEY_QUEUE_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;
  logic [7:0] drop_cnt_next;
  logic [7:0] drop_base;
  logic [8:0] drop_sum;
  logic [2:0] drop_num;

  assign drop_num  = {2'b00, drop_vec[0]} + {2'b00, drop_vec[1]}
                   + {2'b00, drop_vec[2]} + {2'b00, drop_vec[3]};
  // Clear first, then add this cycle's losses.
  assign drop_base = ovf_clr ? 8'd0 : drop_cnt_reg;
  assign drop_sum  = {1'b0, drop_base} + {6'b0, drop_num};

  always_comb begin
    drop_cnt_next = drop_sum[7:0];
    if (drop_sum[8])
      drop_cnt_next = 8'hFF;
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst)
      drop_cnt_reg <= 8'd0;
    else
      drop_cnt_reg <= drop_cnt_next;
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;

  logic       mclk;
  logic       rst;
  logic [3:0] key_en;
  logic [1:0] evt_code;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] fifo_level;
  logic       ovf;
  logic       ovf_clr;
`ifdef KEY_QUEUE_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_tests;
  int n_fail;
  logic [1:0] sb[$];

  key_event_queue #(.ADDR_W(3)) dut (
    .mclk       (mclk),
    .rst        (rst),
    .key_en     (key_en),
    .evt_code   (evt_code),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
`ifdef KEY_QUEUE_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Scoreboard: every accepted head entry is compared with the oldest expected code.
  always @(negedge mclk) begin
    if (!rst && evt_valid && evt_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL pop_unexpected: got code %0d, no event expected", evt_code);
      end else begin
        logic [1:0] exp_code;
        exp_code = sb.pop_front();
        if (evt_code !== exp_code) begin
          n_fail++;
          $display("[TB] FAIL pop_code: got %0d, expected %0d", evt_code, exp_code);
        end else begin
          $display("[TB] pop code=%0d level=%0d", evt_code, fifo_level);
        end
      end
    end
  end

  task automatic test_reset();
    #1;
    n_tests++;
    if (fifo_level !== 4'd0 || evt_valid !== 1'b0 || evt_code !== 2'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: level=%0d valid=%b code=%0d ovf=%b, expected 0/0/0/0",
               fifo_level, evt_valid, evt_code, ovf);
    end
`ifdef KEY_QUEUE_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_drop_cnt: got %0d, expected 0", drop_cnt);
    end
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    evt_ready = 1'b1;
    key_en = 4'b0100;
    sb.push_back(2'd2);
    tick();
    key_en = 4'b0000;
    n_tests++;
    if (evt_valid !== 1'b0 || fifo_level !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL single_edge1: valid=%b level=%0d, expected 0/0", evt_valid, fifo_level);
    end
    tick();
    n_tests++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd2 || fifo_level !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL single_edge2: valid=%b code=%0d level=%0d, expected 1/2/1",
               evt_valid, evt_code, fifo_level);
    end
    tick();
    n_tests++;
    if (evt_valid !== 1'b0 || fifo_level !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL single_edge3: valid=%b level=%0d, expected 0/0", evt_valid, fifo_level);
    end
  endtask

  task automatic test_simultaneous();
    evt_ready = 1'b0;
    key_en = 4'b1011;
    sb.push_back(2'd0);
    sb.push_back(2'd1);
    sb.push_back(2'd3);
    tick();
    key_en = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (fifo_level !== 4'd3 || evt_code !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL simul_level: level=%0d head=%0d, expected 3/0", fifo_level, evt_code);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 10 && fifo_level != 4'd0; i++) tick();
    n_tests++;
    if (fifo_level !== 4'd0 || sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL simul_drain: level=%0d left=%0d, expected 0/0", fifo_level, sb.size());
    end
  endtask

  task automatic test_fill_and_drop();
    evt_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      key_en = 4'b0001 << (i % 4);
      sb.push_back(2'(i % 4));
      tick();
      key_en = 4'b0000;
      tick();
      tick();
    end
    n_tests++;
    if (fifo_level !== 4'd8 || ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fill_full: level=%0d ovf=%b, expected 8/0", fifo_level, ovf);
    end
    key_en = 4'b0010;
    tick();
    key_en = 4'b0000;
    n_tests++;
    if (ovf !== 1'b1 || fifo_level !== 4'd8) begin
      n_fail++;
      $display("[TB] FAIL fill_drop: ovf=%b level=%0d, expected 1/8", ovf, fifo_level);
    end
`ifdef KEY_QUEUE_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL fill_drop_cnt: got %0d, expected 1", drop_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (fifo_level !== 4'd8) begin
        n_fail++;
        $display("[TB] FAIL b2b_level_%0d: got %0d, expected 8", i, fifo_level);
      end
    end
    for (int i = 0; i < 20 && fifo_level != 4'd0; i++) tick();
    n_tests++;
    if (fifo_level !== 4'd0 || sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL b2b_drain: level=%0d left=%0d, expected 0/0", fifo_level, sb.size());
    end
  endtask

  task automatic test_async_reset();
    evt_ready = 1'b0;
    key_en = 4'b1111;
    sb.push_back(2'd0);
    sb.push_back(2'd1);
    sb.push_back(2'd2);
    sb.push_back(2'd3);
    tick();
    key_en = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    key_en = 4'b0001;
    sb.push_back(2'd0);
    tick();
    key_en = 4'b0000;
    tick();
    n_tests++;
    if (fifo_level !== 4'd5) begin
      n_fail++;
      $display("[TB] FAIL rst_prefill: level=%0d, expected 5", fifo_level);
    end
    key_en = 4'b0100;
    tick();
    key_en = 4'b0000;
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    n_tests++;
    if (fifo_level !== 4'd0 || evt_valid !== 1'b0 || ovf !== 1'b0 || evt_code !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_immediate: level=%0d valid=%b ovf=%b code=%0d, expected 0/0/0/0",
               fifo_level, evt_valid, ovf, evt_code);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (fifo_level !== 4'd0 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_pend_cleared: level=%0d valid=%b, expected 0/0", fifo_level, evt_valid);
    end
    key_en = 4'b1000;
    sb.push_back(2'd3);
    tick();
    key_en = 4'b0000;
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_new_edge1: valid=%b, expected 0", evt_valid);
    end
    tick();
    n_tests++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL rst_new_edge2: valid=%b code=%0d, expected 1/3", evt_valid, evt_code);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_tests++;
    if (fifo_level !== 4'd0 || sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL rst_new_drain: level=%0d left=%0d, expected 0/0", fifo_level, sb.size());
    end
  endtask

  task automatic test_ovf_clear();
    evt_ready = 1'b0;
    // Keys 1 and 2 re-pulse while key 0 holds the grant: two losses in one cycle.
    key_en = 4'b0111;
    sb.push_back(2'd0);
    sb.push_back(2'd1);
    sb.push_back(2'd2);
    tick();
    key_en = 4'b0110;
    tick();
    key_en = 4'b0000;
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL multi_drop_ovf: got %b, expected 1", ovf);
    end
`ifdef KEY_QUEUE_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd2) begin
      n_fail++;
      $display("[TB] FAIL multi_drop_cnt: got %0d, expected 2", drop_cnt);
    end
`endif
    for (int i = 0; i < 3; i++) tick();
    // Clear in the same cycle as a new loss: the loss wins.
    key_en = 4'b0011;
    sb.push_back(2'd0);
    sb.push_back(2'd1);
    tick();
    key_en = 4'b0010;
    ovf_clr = 1'b1;
    tick();
    key_en = 4'b0000;
    ovf_clr = 1'b0;
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL clr_vs_drop_ovf: got %b, expected 1", ovf);
    end
`ifdef KEY_QUEUE_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL clr_vs_drop_cnt: got %0d, expected 1", drop_cnt);
    end
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL clr_alone_ovf: got %b, expected 0", ovf);
    end
`ifdef KEY_QUEUE_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL clr_alone_cnt: got %0d, expected 0", drop_cnt);
    end
`endif
    tick();
    n_tests++;
    if (fifo_level !== 4'd5) begin
      n_fail++;
      $display("[TB] FAIL clr_level: got %0d, expected 5", fifo_level);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 15 && fifo_level != 4'd0; i++) tick();
    evt_ready = 1'b0;
    n_tests++;
    if (fifo_level !== 4'd0 || sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL clr_drain: level=%0d left=%0d, expected 0/0", fifo_level, sb.size());
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    key_en    = 4'b0000;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fill_and_drop();
    test_back_to_back();
    test_async_reset();
    test_ovf_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
